// File: rtl/if_id_skid.sv
// Multi-lane IF->ID pipeline stage: a main register driving decode plus a one-packet skid register.
// One cycle from accepted push to dn_valid; up_ready is registered state, so at most one extra packet lands after dn_ready drops.
module if_id_skid #(
  parameter int                LANES       = 2,
  parameter int                ADDR_W      = 32,
  parameter int                INST_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'hBFC0_0000,
  parameter logic [INST_W-1:0] BUBBLE_INST = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     up_valid,
  output logic                     up_ready,
  input  logic [LANES-1:0]         up_lane_vld,
  input  logic [LANES*ADDR_W-1:0]  up_pc,
  input  logic [LANES*INST_W-1:0]  up_inst,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [LANES-1:0]         dn_lane_vld,
  output logic [LANES*ADDR_W-1:0]  dn_pc,
  output logic [LANES*INST_W-1:0]  dn_inst
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                    state, state_nxt;
  logic [LANES-1:0]          main_lane, main_lane_nxt, skid_lane, skid_lane_nxt;
  logic [LANES*ADDR_W-1:0]   main_pc, main_pc_nxt, skid_pc, skid_pc_nxt;
  logic [LANES*INST_W-1:0]   main_inst, main_inst_nxt, skid_inst, skid_inst_nxt;
  logic                      main_valid, skid_valid, push, pop;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);

  assign up_ready    = !skid_valid;
  assign dn_valid    = main_valid;
  assign dn_lane_vld = main_lane;
  assign dn_pc       = main_pc;
  assign dn_inst     = main_inst;

  // Beats with no valid lanes still complete the handshake but are never stored.
  assign push = up_valid && up_ready && (|up_lane_vld);
  assign pop  = main_valid && dn_ready;

  always_comb begin
    state_nxt     = state;
    main_lane_nxt = main_lane;
    main_pc_nxt   = main_pc;
    main_inst_nxt = main_inst;
    skid_lane_nxt = skid_lane;
    skid_pc_nxt   = skid_pc;
    skid_inst_nxt = skid_inst;

    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt     = ONE;
          main_lane_nxt = up_lane_vld;
          main_pc_nxt   = up_pc;
          main_inst_nxt = up_inst;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_lane_nxt = up_lane_vld;
          main_pc_nxt   = up_pc;
          main_inst_nxt = up_inst;
        end else if (push) begin
          state_nxt     = TWO;
          skid_lane_nxt = up_lane_vld;
          skid_pc_nxt   = up_pc;
          skid_inst_nxt = up_inst;
        end else if (pop) begin
          state_nxt     = EMPTY;
          main_lane_nxt = '0;
          main_pc_nxt   = {LANES{RESET_PC}};
          main_inst_nxt = {LANES{BUBBLE_INST}};
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt     = ONE;
          main_lane_nxt = skid_lane;
          main_pc_nxt   = skid_pc;
          main_inst_nxt = skid_inst;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase

    // Redirect discards everything, including a beat offered this cycle.
    if (flush || state_nxt == EMPTY) begin
      state_nxt     = EMPTY;
      main_lane_nxt = '0;
      main_pc_nxt   = {LANES{RESET_PC}};
      main_inst_nxt = {LANES{BUBBLE_INST}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_lane <= '0;
      main_pc   <= {LANES{RESET_PC}};
      main_inst <= {LANES{BUBBLE_INST}};
    end else begin
      state     <= state_nxt;
      main_lane <= main_lane_nxt;
      main_pc   <= main_pc_nxt;
      main_inst <= main_inst_nxt;
    end
  end

  // Skid contents are don't-care while skid is empty, so they need no reset.
  always_ff @(posedge clk) begin
    skid_lane <= skid_lane_nxt;
    skid_pc   <= skid_pc_nxt;
    skid_inst <= skid_inst_nxt;
  end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised successor to the fetch/decode pipeline register: a multi-lane IF->ID stage with valid/ready handshakes on both sides.
- Contains a two-entry skid buffer. Upstream ready is driven from a register, and downstream outputs come straight from flops.
- Sits between the fetch unit (which may deliver up to LANES instructions per beat) and decode.
- Replaces the global stall-vector scheme with local backpressure and an explicit flush for branch and exception redirects.

Parameters:
- LANES, 2, instructions per fetch packet (>=1).
- ADDR_W, 32, PC width per lane.
- INST_W, 32, instruction width per lane.
- RESET_PC, 32'hBFC0_0000, PC value presented on every lane while the stage holds no valid packet.
- BUBBLE_INST, 32'h0000_0000, instruction value presented on every lane while invalid (MIPS nop).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all buffered packets (redirect)
- up_valid  in  1  fetch packet offered
- up_ready  out  1  stage can accept a packet this cycle
- up_lane_vld  in  LANES  per-lane valid of offered packet
- up_pc  in  LANES*ADDR_W  lane i at bits [i*ADDR_W +: ADDR_W]
- up_inst  in  LANES*INST_W  lane i at bits [i*INST_W +: INST_W]
- dn_valid  out  1  packet presented to decode
- dn_ready  in  1  decode accepts the packet
- dn_lane_vld  out  LANES  per-lane valid of presented packet
- dn_pc  out  LANES*ADDR_W  presented PCs
- dn_inst  out  LANES*INST_W  presented instructions

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Storage:
  - main register drives the dn_* outputs directly.
  - skid register holds one overflow packet.
- States, derived from the main/skid valid bits:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid.
  - Main invalid with skid valid is illegal and must never occur.
- Handshake signals:
  - up_ready = !skid_valid, a pure function of registered state. No combinational path from dn_ready to up_ready.
  - dn_valid = main_valid.
  - push = up_valid & up_ready & |up_lane_vld.
  - pop = dn_valid & dn_ready.
- Empty-lane beats: a beat with up_valid=1, up_ready=1 and up_lane_vld=0 is consumed (handshake completes) but not stored.
- Transitions when flush=0:
  - EMPTY: push -> ONE, main<=in.
  - ONE: push&pop -> ONE, main<=in. push&!pop -> TWO, skid<=in. !push&pop -> EMPTY. Otherwise hold.
  - TWO: no push possible. pop -> ONE, main<=skid, skid cleared. Otherwise hold.
- Ordering: packets leave in acceptance order. Lane contents, including up_lane_vld, are never reordered or altered.
- Flush:
  - Next state is EMPTY. Flush beats push, pop and any simultaneous handshake: a packet offered in the flush cycle is dropped.
  - up_ready still shows its pre-flush value during the flush cycle, and the upstream source treats that beat as lost.
  - The cycle after a flush: dn_valid=0, up_ready=1.
- Invalid output values: whenever main is invalid, dn_lane_vld=0 and every lane of dn_pc/dn_inst = RESET_PC/BUBBLE_INST. Values are forced in the register on entry to EMPTY, not by output masking.
- Reset (any cycle, including mid-transfer):
  - next cycle: EMPTY, dn_valid=0, dn_lane_vld=0, dn_pc lanes=RESET_PC, dn_inst lanes=BUBBLE_INST, up_ready=1.
  - skid contents become don't-care.
  - rst has priority over flush.
- Latency and throughput:
  - 1 cycle from an accepted push to dn_valid.
  - Sustains 1 packet/cycle when dn_ready is held high.
  - After dn_ready deasserts, at most one further packet is accepted.
- Widths: lanes are packed LSB-first and no arithmetic is performed. LANES=1 must elaborate correctly.

Test Plan:
- Reset: assert rst 2 cycles with up_valid=1 -> dn_valid=0, dn_lane_vld=2'b00, dn_pc={BFC00000,BFC00000}, dn_inst=0, up_ready=1.
- Streaming: dn_ready=1, push pcs 0x100/0x104, then 0x108/0x10C, then 0x110/0x114 on consecutive cycles -> each packet appears one cycle later, consecutively, up_ready stays 1.
- Backpressure: dn_ready=0, push A then B -> state TWO, up_ready=0, dn shows A. Raise dn_ready -> A popped, then B, then dn_valid=0. No loss, order A,B.
- Flush with push: in state TWO, assert flush with up_valid=1 (packet C) -> next cycle dn_valid=0, up_ready=1. C never appears downstream.
- Empty-lane beat: up_valid=1, up_lane_vld=0 in EMPTY -> handshake completes, next cycle dn_valid=0.
- Partial packet: up_lane_vld=2'b01 -> dn_lane_vld=2'b01 with lane contents passed unchanged.
